ibex_if_id_queue: RTL and testbench
===================================

// Module: ibex_if_id_queue
// PURPOSE
// - Parametrised IF->ID instruction queue; replaces the single IF-ID pipeline register.
// - Holds up to Depth fetched, decompressed instructions with PC, fetch-error, compressed info
//   and the per-instruction one-hot secure enables (RF read A/B, RF write, unit enables).
// - Sits between the compressed decoder and ID; pc_set flushes it.
// - Enables presented to ID are zero whenever no valid instruction is at the head.
// PARAMETERS
// - Depth     2   number of entries, >=1 (need not be a power of two)
// - NumRegs   32  register-file size / one-hot enable width (16 for RV32E)
// - NumUnits  4   unit-enable width {csr, adder, shift, md} (bit 0 = md)
// PORTS
// - clk_i               in   1         clock
// - rst_ni              in   1         asynchronous reset, active low
// - flush_i             in   1         pc_set: discard all entries and any same-cycle push
// - in_valid_i          in   1         push request from fetch
// - in_ready_o          out  1         queue not full
// - in_instr_i          in   32        decompressed instruction
// - in_instr_c_i        in   16        raw compressed bits
// - in_is_compr_i       in   1         instruction was compressed
// - in_illegal_c_i      in   1         illegal compressed instruction
// - in_err_i            in   1         fetch bus error
// - in_err_plus2_i      in   1         fetch error on upper half
// - in_pc_i             in   32        instruction PC
// - in_rf_re_a_i        in   NumRegs   one-hot RF read enable, port A
// - in_rf_re_b_i        in   NumRegs   one-hot RF read enable, port B
// - in_rf_we_i          in   NumRegs   one-hot RF write enable
// - in_unit_en_i        in   NumUnits  functional-unit enables
// - out_valid_o         out  1         head entry valid
// - out_ready_i         in   1         ID consumes head (pop)
// - out_new_o           out  1         first cycle the current head is presented
// - out_<field>_o       out  as in_*   head entry fields, same names/widths as in_*
// - count_o             out  $clog2(Depth+1)  occupancy
// BEHAVIOUR
// - Reset (async): count_o=0, out_valid_o=0, out_new_o=0, in_ready_o=1; all out_* data and
//   enables =0; wr/rd pointers=0.
// - Storage: flop array; wr_ptr/rd_ptr wrap Depth-1 -> 0; no combinational in->out bypass.
// - Push = in_valid_i & in_ready_o & ~flush_i. Pop = out_valid_o & out_ready_i & ~flush_i.
// - in_ready_o = (count_o != Depth); it depends on state only, never on out_ready_i.
// - Latency: an entry pushed in cycle N is at out_* in cycle N+1 if the queue was empty.
// - Push and pop in the same cycle: count unchanged; allowed at any non-full occupancy.
// - Full: no push even if a pop happens in the same cycle. Depth=1 gives one instruction
//   per 2 cycles at most.
// - Empty: pop ignored; out_valid_o=0.
// - flush_i wins over push and pop. Next cycle: count_o=0, pointers=0, out_valid_o=0.
//   Array data may keep stale values but must never be visible.
// - out_valid_o = (count_o != 0).
// - Gating: out_rf_re_a/b_o, out_rf_we_o, out_unit_en_o = head & {W{out_valid_o}}.
//   Other out_* fields are also forced to 0 when !out_valid_o.
// - out_new_o = 1 in the first cycle a given entry is at the head: after the
//   empty->non-empty transition, or after a pop with count>1. It is 0 while the head is
//   stalled (out_ready_i=0).
// - Reset mid-operation: all state returns to reset values immediately; no partial entries.
// - Assertions:
//   - count_o <= Depth.
//   - No push when full.
//   - out_rf_we_o is one-hot or zero ($onehot0).
//   - Inputs known when in_valid_i.
// TESTING
// - Reset, then push pc=0x80 instr=0x00000013 at cycle 1 -> cycle 2: out_valid_o=1,
//   out_pc_o=0x80, out_new_o=1. Hold out_ready_i=0 -> cycle 3: out_new_o=0, data stable.
// - Depth=2, push 3 back-to-back, out_ready_i=0 -> in_ready_o=0 after 2 pushes, count_o=2,
//   third not stored. Pop twice -> PCs come out in order, count_o=0.
// - Wrap: Depth=3, 10 push/pop cycles with random out_ready_i -> FIFO order against a
//   reference model, no loss or duplication.
// - Flush with count_o=2 and a push in the same cycle -> next cycle count_o=0,
//   out_valid_o=0, all enables 0, the pushed entry is gone.
// - Empty queue with in_rf_we_i=1<<5 held but in_valid_i=0 -> out_rf_we_o=0 and
//   out_unit_en_o=0 at all times.
// - Assert rst_ni low while count_o=2 -> out_valid_o=0 and count_o=0 in the same cycle;
//   first push after release appears 1 cycle later.

Source files
------------

// File: rtl/ibex_if_id_queue.sv
// ============================================================================
// Module   : ibex_if_id_queue
// Brief    : IF->ID instruction queue holding decoded instructions and their
//            one-hot secure enables; flushed on pc_set.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ibex_if_id_queue #(
    parameter int unsigned Depth    = 2,
    parameter int unsigned NumRegs  = 32,
    parameter int unsigned NumUnits = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,

    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [31:0]                 in_instr_i,
    input  logic [15:0]                 in_instr_c_i,
    input  logic                        in_is_compr_i,
    input  logic                        in_illegal_c_i,
    input  logic                        in_err_i,
    input  logic                        in_err_plus2_i,
    input  logic [31:0]                 in_pc_i,
    input  logic [NumRegs-1:0]          in_rf_re_a_i,
    input  logic [NumRegs-1:0]          in_rf_re_b_i,
    input  logic [NumRegs-1:0]          in_rf_we_i,
    input  logic [NumUnits-1:0]         in_unit_en_i,

    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic                        out_new_o,
    output logic [31:0]                 out_instr_o,
    output logic [15:0]                 out_instr_c_o,
    output logic                        out_is_compr_o,
    output logic                        out_illegal_c_o,
    output logic                        out_err_o,
    output logic                        out_err_plus2_o,
    output logic [31:0]                 out_pc_o,
    output logic [NumRegs-1:0]          out_rf_re_a_o,
    output logic [NumRegs-1:0]          out_rf_re_b_o,
    output logic [NumRegs-1:0]          out_rf_we_o,
    output logic [NumUnits-1:0]         out_unit_en_o,

    output logic [$clog2(Depth+1)-1:0]  count_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    localparam logic [CntW-1:0] c_DEPTH    = CntW'(Depth);
    localparam logic [PtrW-1:0] c_LAST_PTR = PtrW'(Depth - 1);

    typedef struct packed {
        logic [31:0]         instr;
        logic [15:0]         instr_c;
        logic                is_compr;
        logic                illegal_c;
        logic                err;
        logic                err_plus2;
        logic [31:0]         pc;
        logic [NumRegs-1:0]  rf_re_a;
        logic [NumRegs-1:0]  rf_re_b;
        logic [NumRegs-1:0]  rf_we;
        logic [NumUnits-1:0] unit_en;
    } entry_t;

    entry_t            r_mem [Depth];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [CntW-1:0]   r_count;
    logic              r_new;

    logic              w_valid;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic [CntW-1:0]   w_count_nxt;
    logic              w_new_nxt;
    entry_t            w_in_entry;
    entry_t            w_head;

    assign w_valid = (r_count != '0);
    assign w_ready = (r_count != c_DEPTH);
    assign w_push  = in_valid_i & w_ready & ~flush_i;
    assign w_pop   = w_valid & out_ready_i & ~flush_i;

    assign w_in_entry = '{
        instr:     in_instr_i,
        instr_c:   in_instr_c_i,
        is_compr:  in_is_compr_i,
        illegal_c: in_illegal_c_i,
        err:       in_err_i,
        err_plus2: in_err_plus2_i,
        pc:        in_pc_i,
        rf_re_a:   in_rf_re_a_i,
        rf_re_b:   in_rf_re_b_i,
        rf_we:     in_rf_we_i,
        unit_en:   in_unit_en_i
    };

    always_comb begin
        w_count_nxt = r_count;
        if (flush_i) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // A fresh head appears either when an empty queue takes a push or when a
    // pop leaves something behind (including a simultaneous push at count 1).
    assign w_new_nxt = ~flush_i & ((w_push & ~w_valid) | (w_pop & (w_count_nxt != '0)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_new    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_new   <= w_new_nxt;
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
                end
            end
        end
    end

    // Payload storage carries no reset; stale contents are hidden by the gating below.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    assign w_head = w_valid ? r_mem[r_rd_ptr] : '0;

    assign in_ready_o      = w_ready;
    assign out_valid_o     = w_valid;
    assign out_new_o       = r_new;
    assign count_o         = r_count;
    assign out_instr_o     = w_head.instr;
    assign out_instr_c_o   = w_head.instr_c;
    assign out_is_compr_o  = w_head.is_compr;
    assign out_illegal_c_o = w_head.illegal_c;
    assign out_err_o       = w_head.err;
    assign out_err_plus2_o = w_head.err_plus2;
    assign out_pc_o        = w_head.pc;
    assign out_rf_re_a_o   = w_head.rf_re_a;
    assign out_rf_re_b_o   = w_head.rf_re_b;
    assign out_rf_we_o     = w_head.rf_we;
    assign out_unit_en_o   = w_head.unit_en;

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (r_count <= c_DEPTH)
                else $error("ibex_if_id_queue: occupancy above Depth");
            assert (!(w_push && (r_count == c_DEPTH)))
                else $error("ibex_if_id_queue: push while full");
            assert ($onehot0(out_rf_we_o))
                else $error("ibex_if_id_queue: write enable not one-hot");
            if (in_valid_i) begin
                assert (!$isunknown(w_in_entry))
                    else $error("ibex_if_id_queue: unknown input with in_valid_i");
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ibex_if_id_queue.sv
// ============================================================================
// Module   : tb_ibex_if_id_queue
// Brief    : Directed + randomised scoreboard bench for ibex_if_id_queue
//            (Depth=2 and Depth=3 instances sharing one stimulus).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ibex_if_id_queue;

    localparam int unsigned NR = 32;
    localparam int unsigned NU = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, flush, in_valid, out_ready;
    logic [31:0]   in_instr, in_pc;
    logic [15:0]   in_instr_c;
    logic          in_is_compr, in_illegal_c, in_err, in_err_plus2;
    logic [NR-1:0] in_re_a, in_re_b, in_we;
    logic [NU-1:0] in_unit;

    logic          o2_in_ready, o2_valid, o2_new, o2_is_compr, o2_illegal_c, o2_err, o2_err_plus2;
    logic [31:0]   o2_instr, o2_pc;
    logic [15:0]   o2_instr_c;
    logic [NR-1:0] o2_re_a, o2_re_b, o2_we;
    logic [NU-1:0] o2_unit;
    logic [1:0]    o2_count;

    logic          o3_in_ready, o3_valid, o3_new, o3_is_compr, o3_illegal_c, o3_err, o3_err_plus2;
    logic [31:0]   o3_instr, o3_pc;
    logic [15:0]   o3_instr_c;
    logic [NR-1:0] o3_re_a, o3_re_b, o3_we;
    logic [NU-1:0] o3_unit;
    logic [1:0]    o3_count;

    ibex_if_id_queue #(.Depth(2), .NumRegs(NR), .NumUnits(NU)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(o2_in_ready), .in_instr_i(in_instr),
        .in_instr_c_i(in_instr_c), .in_is_compr_i(in_is_compr), .in_illegal_c_i(in_illegal_c),
        .in_err_i(in_err), .in_err_plus2_i(in_err_plus2), .in_pc_i(in_pc),
        .in_rf_re_a_i(in_re_a), .in_rf_re_b_i(in_re_b), .in_rf_we_i(in_we), .in_unit_en_i(in_unit),
        .out_valid_o(o2_valid), .out_ready_i(out_ready), .out_new_o(o2_new),
        .out_instr_o(o2_instr), .out_instr_c_o(o2_instr_c), .out_is_compr_o(o2_is_compr),
        .out_illegal_c_o(o2_illegal_c), .out_err_o(o2_err), .out_err_plus2_o(o2_err_plus2),
        .out_pc_o(o2_pc), .out_rf_re_a_o(o2_re_a), .out_rf_re_b_o(o2_re_b),
        .out_rf_we_o(o2_we), .out_unit_en_o(o2_unit), .count_o(o2_count)
    );

    ibex_if_id_queue #(.Depth(3), .NumRegs(NR), .NumUnits(NU)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(o3_in_ready), .in_instr_i(in_instr),
        .in_instr_c_i(in_instr_c), .in_is_compr_i(in_is_compr), .in_illegal_c_i(in_illegal_c),
        .in_err_i(in_err), .in_err_plus2_i(in_err_plus2), .in_pc_i(in_pc),
        .in_rf_re_a_i(in_re_a), .in_rf_re_b_i(in_re_b), .in_rf_we_i(in_we), .in_unit_en_i(in_unit),
        .out_valid_o(o3_valid), .out_ready_i(out_ready), .out_new_o(o3_new),
        .out_instr_o(o3_instr), .out_instr_c_o(o3_instr_c), .out_is_compr_o(o3_is_compr),
        .out_illegal_c_o(o3_illegal_c), .out_err_o(o3_err), .out_err_plus2_o(o3_err_plus2),
        .out_pc_o(o3_pc), .out_rf_re_a_o(o3_re_a), .out_rf_re_b_o(o3_re_b),
        .out_rf_we_o(o3_we), .out_unit_en_o(o3_unit), .count_o(o3_count)
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] sb2[$];
    logic [31:0] sb3[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_push(input logic [31:0] pc, input logic [31:0] instr, input int we_bit);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        in_we    = NR'(1) << we_bit;
        in_re_a  = NR'(1) << ((we_bit + 1) % NR);
        in_re_b  = NR'(1) << ((we_bit + 2) % NR);
        in_unit  = NU'(1) << (we_bit % NU);
    endtask

    // Scoreboard bookkeeping from the values visible just before the clock edge.
    task automatic step();
        logic p2, q2, p3, q3;
        p2 = in_valid && o2_in_ready && !flush;
        q2 = o2_valid && out_ready && !flush;
        p3 = in_valid && o3_in_ready && !flush;
        q3 = o3_valid && out_ready && !flush;
        if (q2) begin
            if (sb2.size() == 0) chk("d2_pop_unexpected", 32'(o2_valid), 32'd0);
            else                 chk("d2_pop_pc", o2_pc, sb2.pop_front());
        end
        if (p2) sb2.push_back(in_pc);
        if (q3) begin
            if (sb3.size() == 0) chk("d3_pop_unexpected", 32'(o3_valid), 32'd0);
            else                 chk("d3_pop_pc", o3_pc, sb3.pop_front());
        end
        if (p3) sb3.push_back(in_pc);
        if (flush) begin
            sb2.delete();
            sb3.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_instr_c = 16'h4501; in_is_compr = 1'b0;
        in_illegal_c = 1'b0; in_err = 1'b0; in_err_plus2 = 1'b0;
        in_re_a = '0; in_re_b = '0; in_we = '0; in_unit = '0;

        #12;
        chk("rst_count", 32'(o2_count), 0);
        chk("rst_valid", 32'(o2_valid), 0);
        chk("rst_new", 32'(o2_new), 0);
        chk("rst_in_ready", 32'(o2_in_ready), 1);
        chk("rst_pc", o2_pc, 0);
        chk("rst_we", o2_we, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single push, then stall the head
        set_push(32'h80, 32'h0000_0013, 3);
        step();
        in_valid = 1'b0;
        chk("t1_valid", 32'(o2_valid), 1);
        chk("t1_pc", o2_pc, 32'h80);
        chk("t1_instr", o2_instr, 32'h13);
        chk("t1_new", 32'(o2_new), 1);
        chk("t1_count", 32'(o2_count), 1);
        chk("t1_we", o2_we, 32'h8);
        chk("t1_re_a", o2_re_a, 32'h10);
        chk("t1_unit", 32'(o2_unit), 32'h8);
        step();
        chk("t1_new_stall", 32'(o2_new), 0);
        chk("t1_pc_stable", o2_pc, 32'h80);
        chk("t1_valid_stable", 32'(o2_valid), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_count_after_pop", 32'(o2_count), 0);
        chk("t1_valid_after_pop", 32'(o2_valid), 0);
        chk("t1_pc_gated", o2_pc, 0);
        chk("t1_we_gated", o2_we, 0);

        // Enables presented to an empty queue must never leak through
        in_we = NR'(1) << 5;
        in_unit = '1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("empty_we", o2_we, 0);
            chk("empty_unit", 32'(o2_unit), 0);
            chk("empty_we_d3", o3_we, 0);
        end

        // Fill Depth=2 with three back-to-back pushes
        for (int i = 0; i < 3; i++) begin
            set_push(32'h100 + 32'(4 * i), 32'h0000_0093 + 32'(i), i + 1);
            step();
            chk("full_count", 32'(o2_count), (i == 0) ? 1 : 2);
            if (i == 1) chk("full_in_ready", 32'(o2_in_ready), 0);
        end
        in_valid = 1'b0;
        chk("full_head_pc", o2_pc, 32'h100);
        chk("full_d3_count", 32'(o3_count), 3);
        out_ready = 1'b1;
        step();
        chk("pop1_new", 32'(o2_new), 1);
        chk("pop1_pc", o2_pc, 32'h104);
        chk("pop1_we", o2_we, 32'h4);
        chk("pop1_count", 32'(o2_count), 1);
        step();
        out_ready = 1'b0;
        chk("pop2_count", 32'(o2_count), 0);
        chk("pop2_valid", 32'(o2_valid), 0);

        // Flush at count=2 with a same-cycle push
        set_push(32'h200, 32'h1, 4);
        step();
        set_push(32'h204, 32'h2, 6);
        step();
        chk("fl_pre_count", 32'(o2_count), 2);
        set_push(32'h208, 32'h3, 7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_count", 32'(o2_count), 0);
        chk("fl_valid", 32'(o2_valid), 0);
        chk("fl_we", o2_we, 0);
        chk("fl_re_a", o2_re_a, 0);
        chk("fl_re_b", o2_re_b, 0);
        chk("fl_unit", 32'(o2_unit), 0);
        chk("fl_pc", o2_pc, 0);
        chk("fl_in_ready", 32'(o2_in_ready), 1);
        chk("fl_d3_count", 32'(o3_count), 0);
        set_push(32'h20C, 32'h4, 9);
        step();
        in_valid = 1'b0;
        chk("fl_next_pc", o2_pc, 32'h20C);
        chk("fl_next_count", 32'(o2_count), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Asynchronous reset with two entries held
        set_push(32'h280, 32'h5, 10);
        step();
        set_push(32'h284, 32'h6, 11);
        step();
        in_valid = 1'b0;
        chk("ar_pre_count", 32'(o2_count), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(o2_valid), 0);
        chk("ar_count", 32'(o2_count), 0);
        chk("ar_in_ready", 32'(o2_in_ready), 1);
        chk("ar_d3_count", 32'(o3_count), 0);
        sb2.delete();
        sb3.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_push(32'h300, 32'h7, 12);
        step();
        in_valid = 1'b0;
        chk("ar_push_valid", 32'(o2_valid), 1);
        chk("ar_push_pc", o2_pc, 32'h300);
        chk("ar_push_new", 32'(o2_new), 1);
        out_ready = 1'b1;
        step();

        // Randomised traffic through the wrapping pointers
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) != 0) set_push(32'h400 + 32'(4 * k), 32'(k), k % 32);
            else                           in_valid = 1'b0;
            out_ready = ($urandom_range(0, 1) == 1);
            step();
            chk("rnd_d3_count", 32'(o3_count), 32'(sb3.size()));
            chk("rnd_d2_count", 32'(o2_count), 32'(sb2.size()));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("drain_d3_count", 32'(o3_count), 0);
        chk("drain_d2_count", 32'(o2_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
